// File: rtl/ep_turn_arbiter_if.sv
// rtl/ep_turn_arbiter_if.sv - request/driven/turn bundle between TLP engines and the TRN turn arbiter
interface ep_turn_arbiter_if #(
    parameter int NUM_CH  = 4,
    parameter int CH_ID_W = 2
);
    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  driven;
    logic [NUM_CH-1:0]  turn;
    logic [CH_ID_W-1:0] grant_id;
    logic               busy;
    logic               ack_timeout;
    logic               proto_err;

    // master: the arbiter side; slave: the requesting engines
    modport master (
        input  req,
        input  driven,
        output turn,
        output grant_id,
        output busy,
        output ack_timeout,
        output proto_err
    );

    modport slave (
        output req,
        output driven,
        input  turn,
        input  grant_id,
        input  busy,
        input  ack_timeout,
        input  proto_err
    );
endinterface

// File: rtl/ep_turn_arbiter.sv
// rtl/ep_turn_arbiter.sv - N-channel round-robin turn arbiter for the TRN transmit path
// Optional: EP_ARB_CH0_PRIORITY_EN gives channel 0 strict priority over the rotating channels.
module ep_turn_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int CH_ID_W     = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              trn_clk,
    input  logic              reset,
    ep_turn_arbiter_if.master arb
);
    localparam int TMO_W = $clog2(ACK_TIMEOUT);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CH_ID_W-1:0] RR_INIT  = CH_ID_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        BUSY     = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CH_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_CH-1:0]  turn_q, turn_d;
    logic [CH_ID_W-1:0] grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic               ack_timeout_q, ack_timeout_d;
    logic               proto_err_q, proto_err_d;

    logic               pick_vld;
    logic [CH_ID_W-1:0] pick_id;
    logic               prio_hit;
    logic [NUM_CH-1:0]  own_mask;
    logic               own_driven;
    logic               other_driven;
    int                 off;
    int                 best_off;

`ifdef EP_ARB_CH0_PRIORITY_EN
    assign prio_hit = arb.req[0];
`else
    assign prio_hit = 1'b0;
`endif

    assign own_mask     = NUM_CH'(1) << grant_id_q;
    assign own_driven   = |(arb.driven & own_mask);
    assign other_driven = |(arb.driven & ~own_mask);

    // Round-robin search: the requester closest after rr_ptr (modulo NUM_CH) wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        best_off = NUM_CH;
        off      = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            off = (j + NUM_CH - 1 - int'(rr_ptr_q)) % NUM_CH;
            if (arb.req[j] && (off < best_off)) begin
                best_off = off;
                pick_vld = 1'b1;
                pick_id  = CH_ID_W'(j);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        tmo_cnt_d     = tmo_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        turn_d        = '0;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        ack_timeout_d = 1'b0;
        proto_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (|arb.driven) begin
                    // nobody holds a turn here, so any driven bit is a protocol violation
                    proto_err_d = 1'b1;
                end else if (prio_hit) begin
                    turn_d     = NUM_CH'(1);
                    grant_id_d = '0;
                    busy_d     = 1'b1;
                    tmo_cnt_d  = '0;
                    state_d    = WAIT_ACK;
                end else if (pick_vld) begin
                    turn_d     = NUM_CH'(1) << pick_id;
                    grant_id_d = pick_id;
                    rr_ptr_d   = pick_id;
                    busy_d     = 1'b1;
                    tmo_cnt_d  = '0;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                proto_err_d = other_driven;
                if (own_driven) begin
                    state_d = BUSY;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    ack_timeout_d = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            BUSY: begin
                proto_err_d = other_driven;
                if (!own_driven) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= RR_INIT;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            turn_q        <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            ack_timeout_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            turn_q        <= turn_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            ack_timeout_q <= ack_timeout_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign arb.turn        = turn_q;
    assign arb.grant_id    = grant_id_q;
    assign arb.busy        = busy_q;
    assign arb.ack_timeout = ack_timeout_q;
    assign arb.proto_err   = proto_err_q;
endmodule

// File: doc/ep_turn_arbiter.md
Name: ep_turn_arbiter

Overview:
- N-channel successor to the two-party rx/tx turn arbiter on the TRN transmit interface.
- Each engine (rx completion, tx DMA, register reads, ...) requests the shared trn_td/trn_tsrc_rdy path, receives a one-cycle turn pulse, and owns the bus while its driven flag is high.
- Adds per-channel request gating, round-robin fairness, an acknowledge timeout, a programmable inter-grant gap and error reporting.
- Sits between the TLP-sourcing engines and the PCIe endpoint core.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- CH_ID_W, 2, width of grant_id; must satisfy 2^CH_ID_W >= NUM_CH.
- ACK_TIMEOUT, 16, cycles allowed between turn pulse and driven rise (>=2).
- GAP_CYCLES, 1, idle cycles after a release before re-arbitration (>=1).

Ports:
- trn_clk  in  1  TRN clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CH  per-channel request, level.
- driven  in  NUM_CH  per-channel "I own the bus" flag.
- turn  out  NUM_CH  one-hot, one-cycle grant pulse, registered.
- grant_id  out  CH_ID_W  index of the last granted channel, registered.
- busy  out  1  high from grant until the end of GAP.
- ack_timeout  out  1  one-cycle pulse when the granted channel fails to take the bus.
- proto_err  out  1  one-cycle pulse on an illegal driven assertion.

Behaviour:
- Reset values, applied at the next edge with reset high (including mid-transfer): turn=0, grant_id=0, busy=0, ack_timeout=0, proto_err=0, fsm=IDLE, rr_ptr=NUM_CH-1, tmo_cnt=0, gap_cnt=0.
- States: IDLE, WAIT_ACK, BUSY, GAP. Unused encodings go to IDLE.
- IDLE:
  - If driven==0 and req!=0, select k = the first set req bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - At the next edge: turn[k]=1, grant_id=k, rr_ptr=k, busy=1, tmo_cnt=0, fsm=WAIT_ACK.
  - Latency: req sampled at edge n, turn high during cycle n..n+1.
- IDLE with any driven bit high: no grant, proto_err pulse, stay in IDLE. driven wins over simultaneous req.
- WAIT_ACK:
  - turn returns to 0 (exactly one cycle wide). tmo_cnt increments each cycle.
  - driven[grant_id]=1 -> BUSY.
  - Any other driven bit high -> proto_err pulse, state unchanged.
  - tmo_cnt == ACK_TIMEOUT-1 with no ack -> ack_timeout pulse, gap_cnt=0, GAP.
  - Dropping req after the turn pulse is allowed; only driven or the timeout exits the state.
- BUSY:
  - Hold while driven[grant_id]=1. Its fall -> gap_cnt=0, GAP.
  - Another driven bit high -> proto_err pulse each such cycle.
  - No timeout in BUSY.
- GAP:
  - gap_cnt counts to GAP_CYCLES-1, then fsm=IDLE and busy=0 at that edge.
  - First new grant (turn pulse) appears GAP_CYCLES+1 cycles after the driven fall.
- Counters saturate and never wrap. tmo_cnt and gap_cnt are wide enough for their parameter.
- rr_ptr wrap: after granting NUM_CH-1, the search starts at 0.
- A single requester is re-granted back-to-back every cycle the FSM returns to IDLE.
- Equivalence: NUM_CH=2 with GAP_CYCLES=1 and req tied high reproduces the alternating rx/tx turn scheme.

Optional Feature:
- Macro: EP_ARB_CH0_PRIORITY_EN.
- Defined: channel 0 has strict priority. In IDLE, req[0]=1 grants channel 0 regardless of rr_ptr, and rr_ptr is not updated on channel-0 grants. The remaining channels rotate among themselves.
- Undefined: pure round-robin over all channels, as described above.

Test Plan:
- Reset, NUM_CH=4, req=4'b1111, each driven held 3 cycles after its turn: turns occur in order 0,1,2,3,0; each turn pulse is 1 cycle; grant_id follows; busy is low only during the IDLE cycle.
- req=4'b0100 only, driven never asserted: turn[2] pulse, then ack_timeout pulse exactly ACK_TIMEOUT(16) cycles after the turn edge, busy drops 1 cycle later (GAP=1), then turn[2] again.
- Granted ch1 in BUSY, driven=4'b1010: proto_err pulses every cycle ch3 is high; state stays BUSY until driven[1] falls.
- GAP_CYCLES=3, ch0 drops driven at edge t while req[1]=1: turn[1] rises at edge t+4.
- Assert reset for 1 cycle during BUSY: next cycle all outputs 0, rr_ptr=3; with req=4'b1111 the first grant after reset is ch0.
- EP_ARB_CH0_PRIORITY_EN defined, req=4'b1111 continuous: channel 0 is granted every arbitration; with req[0]=0, channels 1,2,3 rotate.
